// File: rtl/instr_fetch_responder.sv
// Instruction store with one-cycle fetch into a 2-entry in-order response FIFO.
// Define FETCH_ALIGN_CHECK_EN to fault fetches whose byte address is not word aligned.
module instr_fetch_responder #(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [REG_BITS-1:0]      req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [REG_BITS-1:0]      rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [REG_BITS-1:0]      ld_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [REG_BITS-3:0] DEPTH_IDX = (REG_BITS-2)'(DEPTH);
    localparam logic [AW:0]         DEPTH_LD  = (AW+1)'(DEPTH);

    logic [REG_BITS-1:0] mem [DEPTH];

    logic [REG_BITS-3:0] word_idx;
    logic                in_range;
    logic                misaligned;
    logic                fetch_err;
    logic [REG_BITS-1:0] fetch_data;

    logic [REG_BITS-1:0] fifo_data [2];
    logic [1:0]          fifo_err;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic                push;
    logic                pop;

    // Store contents survive reset; the nonblocking write makes a same-edge fetch see the old word.
    always_ff @(posedge clk) begin
        if (ld_en && ({1'b0, ld_addr} < DEPTH_LD)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign word_idx = req_addr[REG_BITS-1:2];
    assign in_range = (word_idx < DEPTH_IDX);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];
    assign misaligned       = 1'b0;
`endif

    always_comb begin
        fetch_err  = misaligned || !in_range;
        fetch_data = '0;
        if (!fetch_err) begin
            fetch_data = mem[word_idx[AW-1:0]];
        end
    end

    assign req_ready = (count < 2'd2);
    assign rsp_valid = (count != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Entries capture data and error at acceptance, so later store writes cannot alter them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_err     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= fetch_data;
                fifo_err[wr_ptr]  <= fetch_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rsp_data = fifo_data[rd_ptr];
    assign rsp_err  = fifo_err[rd_ptr];

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 Parameter REG_BITS, default 32, SHALL set the width of the address, load-data and response-data buses.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of REG_BITS-wide words in the instruction store.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the active-high asynchronous reset.
REQ-005 Port req_valid, input, 1 bit, SHALL signal a fetch request from the PC side.
REQ-006 Port req_ready, output, 1 bit, SHALL signal that a request can be accepted this cycle.
REQ-007 Port req_addr, input, REG_BITS, SHALL carry the byte address of the fetch.
REQ-008 Port rsp_valid, output, 1 bit, SHALL signal that a response is presented.
REQ-009 Port rsp_ready, input, 1 bit, SHALL signal that the consumer takes the response.
REQ-010 Port rsp_data, output, REG_BITS, SHALL carry the fetched instruction word.
REQ-011 Port rsp_err, output, 1 bit, SHALL flag a faulted fetch.
REQ-012 Port ld_en, input, 1 bit, SHALL enable a store write.
REQ-013 Port ld_addr, input, clog2(DEPTH) bits, SHALL carry the word index for a store write.
REQ-014 Port ld_data, input, REG_BITS, SHALL carry the word for a store write.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-016 Word index SHALL be req_addr >> 2, and bits [1:0] SHALL NOT take part in indexing.
REQ-017 An accepted request SHALL be pushed into a 2-entry response FIFO on the same edge, with its data and error flag resolved at that edge.
REQ-018 Latency SHALL be one cycle: with the FIFO empty, rsp_valid SHALL rise on the edge that accepts the request.
REQ-019 req_ready SHALL be 1 exactly when the FIFO count is below 2, combinationally from the count only.
REQ-020 rsp_valid SHALL be 1 exactly when the count is nonzero.
REQ-021 rsp_data and rsp_err SHALL present the head entry and SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-022 The head SHALL pop on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-024 Responses SHALL leave in request order, and the FIFO pointers SHALL wrap modulo 2.
REQ-025 A word index >= DEPTH SHALL produce rsp_err=1 and rsp_data=0.
REQ-026 A store write SHALL occur on a rising edge where ld_en=1.
REQ-027 When a store write and a fetch of the same word fall on one edge, the fetch SHALL return the pre-write word.
REQ-028 A store write SHALL NOT affect entries already in the FIFO.
REQ-029 With ld_addr >= DEPTH, ld_en SHALL be ignored.

Reset
REQ-030 While reset=1, count SHALL be 0, rsp_valid 0, rsp_data 0, rsp_err 0 and req_ready 1, all independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all pending responses.
REQ-032 Store contents SHALL NOT be reset.
REQ-033 No request SHALL be accepted while reset=1.

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN, when defined, SHALL make req_addr[1:0] != 0 produce rsp_err=1 and rsp_data=0, taking precedence over the range check.
REQ-035 Without FETCH_ALIGN_CHECK_EN, bits [1:0] SHALL be ignored, and misaligned addresses SHALL return the word at index req_addr>>2 with rsp_err=0.

Verification
REQ-036 Load word 0=0x00000013 and word 1=0x00A00093, then request addr 0x0 with rsp_ready=1 -> rsp_valid=1 one edge later with rsp_data=0x00000013 and rsp_err=0.
REQ-037 Hold rsp_ready=0 and issue requests 0x0, 0x4, 0x8 back-to-back -> req_ready=0 after two accepts; raise rsp_ready -> data for 0x0 then 0x4, and 0x8 is accepted after the first pop.
REQ-038 Request addr 0x400 with DEPTH=256 -> rsp_err=1 and rsp_data=0x00000000.
REQ-039 Request addr 0x2 -> with FETCH_ALIGN_CHECK_EN, rsp_err=1 and rsp_data=0; without it, rsp_data=word 0 and rsp_err=0.
REQ-040 Drive ld_en to word 1 with 0xFFFFFFFF on the same edge as a fetch of 0x4 -> response is 0x00A00093, and a following fetch of 0x4 returns 0xFFFFFFFF.
REQ-041 Assert reset asynchronously with 2 responses pending -> rsp_valid=0 and req_ready=1 immediately; after release, a fetch of 0x0 returns the loaded word.
